sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single downstream memory port (toward the AXI bridge) between the core's
//  instruction-fetch requester (64-bit reads) and the LSU/data requester (32-bit reads and writes).
//  Sits between the core's inst_sram/data_sram side and the bridge.
//  Holds exactly one transaction in flight: grant, address phase, response phase, back to idle.
// PARAMETERS
//  ADDR_W        32  address width, both requesters and memory side
//  STARVE_LIMIT  4   consecutive data grants allowed while inst_req is pending before inst is forced (range 1..15)
// PORTS
//  clk            in   1   single clock, rising edge
//  resetn         in   1   asynchronous active-low reset
//  inst_req       in   1   fetch request (read only); held until inst_addr_ok
//  inst_addr      in   32  fetch address, 8-byte aligned
//  inst_addr_ok   out  1   fetch request accepted this cycle
//  inst_data_ok   out  1   fetch data valid this cycle
//  inst_rdata     out  64  fetch data (two instructions)
//  data_req       in   1   data request; held until data_addr_ok
//  data_wr        in   1   1 = write, 0 = read
//  data_wstrb     in   4   byte enables for writes
//  data_addr      in   32  data address
//  data_wdata     in   32  write data
//  data_addr_ok   out  1   data request accepted this cycle
//  data_data_ok   out  1   read data valid / write acknowledged this cycle
//  data_rdata     out  32  read data = mem_rdata[31:0]
//  mem_req        out  1   downstream request, held until mem_addr_ok
//  mem_wr         out  1   downstream write
//  mem_size64     out  1   1 = 64-bit fetch, 0 = 32-bit data access
//  mem_wstrb      out  4   downstream byte enables (0 for reads)
//  mem_addr       out  32  downstream address
//  mem_wdata      out  32  downstream write data
//  mem_addr_ok    in   1   downstream accepted the request
//  mem_data_ok    in   1   downstream response valid
//  mem_rdata      in   64  downstream read data
// BEHAVIOUR
//  - Reset: async on resetn low. All state cleared; FSM = IDLE; starve counter = 0; request regs = 0.
//    All outputs 0. Any in-flight transaction is abandoned and no data_ok is issued for it.
//  - FSM states: IDLE -> ADDR -> RESP -> IDLE.
//  - IDLE: choose a winner among asserted requests (combinationally).
//    The winner's *_addr_ok is 1 in that same cycle. The request (addr, wr, wstrb, wdata, owner) is latched.
//    Next state is ADDR. No request pending: stay in IDLE.
//  - ADDR: mem_req = 1 with the latched fields; mem_size64 = (owner == inst).
//    mem_addr_ok = 1 -> RESP next cycle. mem_data_ok is ignored in ADDR.
//  - RESP: mem_req = 0. Wait for mem_data_ok.
//    Same cycle: the owner's *_data_ok = 1; inst_rdata = mem_rdata, or data_rdata = mem_rdata[31:0].
//    Next state is IDLE. Writes also complete with data_data_ok.
//  - Minimum occupancy is 3 cycles per transaction: grant, address accepted, response.
//    The next grant comes in the cycle after data_ok; there is no overlap.
//  - addr_ok / data_ok are never asserted outside their own state and never go to the non-owner.
//  - Fixed priority (default): data wins over inst.
//    - Starve counter increments on each data grant while inst_req = 1. It clears on each inst grant,
//      and also clears in an IDLE cycle with inst_req = 0.
//    - Counter == STARVE_LIMIT: inst wins regardless of data_req. The counter saturates at the limit.
//  - Simultaneous events: in IDLE only one addr_ok per cycle. Requests that are not granted must stay
//    asserted (requester rule); the arbiter does not queue them.
//  - Latched request fields are stable from grant until mem_addr_ok. Requester inputs are don't-care
//    after their addr_ok.
//  - Unaligned inst_addr (bits[2:0] != 0) is passed through unchanged; alignment is the fetch unit's duty.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//   - 1-bit last_owner register, reset value = inst.
//   - When both requests are present, the owner not served last wins. A single request is always granted.
//   - The starve counter and STARVE_LIMIT are unused; the counter logic is not compiled in.
//  ARB_ROUND_ROBIN_EN undefined: fixed data priority with the starvation guard described above.
// TESTING
//  1. Reset mid-RESP (inst fetch outstanding, pull resetn low for 1 cycle):
//     -> all outputs 0 immediately, state IDLE, no inst_data_ok afterwards.
//  2. Single fetch, inst_addr=0xBFC0_0000; mem_addr_ok at ADDR cycle 1; mem_data_ok 2 cycles later with
//     mem_rdata=0x2408_0001_3C08_BFC0 -> inst_addr_ok at cycle 0, mem_req cycle 1 with mem_size64=1,
//     inst_data_ok with inst_rdata = that value.
//  3. Data write, addr=0x8000_0010, wstrb=4'b0011, wdata=0x1234_5678 -> mem_wr=1, mem_wstrb=4'b0011,
//     mem_size64=0; data_data_ok pulses once on mem_data_ok.
//  4. inst_req and data_req both held high, fixed priority, STARVE_LIMIT=4, 1-cycle memory
//     -> grant order D,D,D,D,I,D,D,D,D,I.
//  5. Same stimulus with ARB_ROUND_ROBIN_EN -> grant order D,I,D,I...
//     (the first grant goes to data because last_owner resets to inst).
//  6. Backpressure: mem_addr_ok held low 10 cycles -> mem_req stays 1 with fields stable;
//     no addr_ok to the other requester during those cycles.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - one-in-flight arbiter sharing the memory port between fetch and data requesters
// Optional ARB_ROUND_ROBIN_EN swaps fixed data priority (with starvation guard) for round-robin.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [63:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic              mem_size64,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t            state;
  logic              owner_inst;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic              inst_wins;
  logic              grant_inst;
  logic              grant_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_inst;

  assign inst_wins = !data_req || !last_inst;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_inst <= 1'b1;
    end else if (grant_inst) begin
      last_inst <= 1'b1;
    end else if (grant_data) begin
      last_inst <= 1'b0;
    end
  end
`else
  logic [3:0] starve_cnt;

  assign inst_wins = !data_req || (starve_cnt == 4'(STARVE_LIMIT));

  // Counts data grants that bypassed a waiting fetch; saturates so the fetch stays forced.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_inst) begin
        starve_cnt <= '0;
      end else if (grant_data && inst_req) begin
        if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
      end else if (!inst_req) begin
        starve_cnt <= '0;
      end
    end
  end
`endif

  assign grant_inst = (state == IDLE) && inst_req && inst_wins;
  assign grant_data = (state == IDLE) && data_req && !grant_inst;

  // Grants are gated by reset so nothing leaks out while resetn is held low.
  assign inst_addr_ok = resetn && grant_inst;
  assign data_addr_ok = resetn && grant_data;
  assign inst_data_ok = (state == RESP) && owner_inst && mem_data_ok;
  assign data_data_ok = (state == RESP) && !owner_inst && mem_data_ok;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 64'd0;
  assign data_rdata   = data_data_ok ? mem_rdata[31:0] : 32'd0;

  assign mem_req    = (state == ADDR);
  assign mem_wr     = mem_req && wr_q;
  assign mem_size64 = mem_req && owner_inst;
  assign mem_wstrb  = (mem_req && wr_q) ? wstrb_q : 4'd0;
  assign mem_addr   = mem_req ? addr_q : '0;
  assign mem_wdata  = (mem_req && wr_q) ? wdata_q : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner_inst <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wstrb_q    <= 4'd0;
      wdata_q    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_inst) begin
            owner_inst <= 1'b1;
            addr_q     <= inst_addr;
            wr_q       <= 1'b0;
            wstrb_q    <= 4'd0;
            wdata_q    <= 32'd0;
            state      <= ADDR;
          end else if (grant_data) begin
            owner_inst <= 1'b0;
            addr_q     <= data_addr;
            wr_q       <= data_wr;
            wstrb_q    <= data_wr ? data_wstrb : 4'd0;
            wdata_q    <= data_wdata;
            state      <= ADDR;
          end
        end
        ADDR: if (mem_addr_ok) state <= RESP;
        RESP: if (mem_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
